// File: rtl/timer_counter_bank_if.sv
// Bus bundle for timer_counter_bank: register strobes, registered read data and per-channel irq.
// The slave modport is the timer bank; the master modport is the bus controller.
interface timer_counter_bank_if #(
    parameter int NUM_CHANNELS        = 4,
    parameter int TIMER_COUNTER_WIDTH = 8
);
    logic [$clog2(NUM_CHANNELS)+1:0]  addr;
    logic                             wr_en;
    logic [TIMER_COUNTER_WIDTH-1:0]   wr_data;
    logic                             rd_en;
    logic [TIMER_COUNTER_WIDTH-1:0]   rd_data;
    logic [NUM_CHANNELS-1:0]          irq;

    modport master (
        output addr, wr_en, wr_data, rd_en,
        input  rd_data, irq
    );

    modport slave (
        input  addr, wr_en, wr_data, rd_en,
        output rd_data, irq
    );
endinterface

// File: rtl/timer_counter_bank.sv
// Bank of memory-mapped prescaled up/down timer/counters with auto-reload and sticky irq flags.
// Define TIMER_COUNTER_ONESHOT_EN to add CTRL bit4 (oneshot: stop the channel on its wrap tick).
module timer_counter_bank #(
    parameter int NUM_CHANNELS        = 4,
    parameter int TIMER_COUNTER_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    timer_counter_bank_if.slave   bus
);
    localparam int W = TIMER_COUNTER_WIDTH;

    logic [W-1:0] max_q    [NUM_CHANNELS];
    logic [W-1:0] max_d    [NUM_CHANNELS];
    logic [W-1:0] period_q [NUM_CHANNELS];
    logic [W-1:0] period_d [NUM_CHANNELS];
    logic [W-1:0] pre_q    [NUM_CHANNELS];
    logic [W-1:0] pre_d    [NUM_CHANNELS];
    logic [W-1:0] count_q  [NUM_CHANNELS];
    logic [W-1:0] count_d  [NUM_CHANNELS];

    logic [NUM_CHANNELS-1:0] en_q, en_d;
    logic [NUM_CHANNELS-1:0] dir_q, dir_d;
    logic [NUM_CHANNELS-1:0] flag_q, flag_d;
    logic [NUM_CHANNELS-1:0] ie_q, ie_d;
`ifdef TIMER_COUNTER_ONESHOT_EN
    logic [NUM_CHANNELS-1:0] os_q, os_d;
`endif

    logic [W-1:0] rd_data_q, rd_mux;
    logic [4:0]   chan;
    logic [1:0]   off;
    logic         chan_ok;

    assign chan    = 5'(bus.addr >> 2);
    assign off     = bus.addr[1:0];
    assign chan_ok = (chan < 5'(NUM_CHANNELS));

    always_comb begin : next_state
        logic sel, wr_ctrl, wr_per, wr_cnt, tick, wrap;
        max_d    = max_q;
        period_d = period_q;
        pre_d    = pre_q;
        count_d  = count_q;
        en_d     = en_q;
        dir_d    = dir_q;
        flag_d   = flag_q;
        ie_d     = ie_q;
`ifdef TIMER_COUNTER_ONESHOT_EN
        os_d     = os_q;
`endif
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            sel     = bus.wr_en && chan_ok && (chan == 5'(c));
            wr_ctrl = sel && (off == 2'd1);
            wr_per  = sel && (off == 2'd2);
            wr_cnt  = sel && (off == 2'd3);
            tick    = en_q[c] && (pre_q[c] == period_q[c]);
            // a COUNT write swallows a coincident tick, including its flag
            wrap    = tick && !wr_cnt &&
                      (dir_q[c] ? (count_q[c] == '0) : (count_q[c] == max_q[c]));

            if (sel && (off == 2'd0)) max_d[c] = bus.wr_data;
            if (wr_per) period_d[c] = bus.wr_data;

            if (wr_per || wr_cnt)   pre_d[c] = '0;
            else if (en_q[c])       pre_d[c] = tick ? '0 : pre_q[c] + W'(1);

            if (wr_cnt)
                count_d[c] = bus.wr_data;
            else if (tick && dir_q[c])
                count_d[c] = (count_q[c] == '0) ? max_q[c] : count_q[c] - W'(1);
            else if (tick)
                count_d[c] = (count_q[c] == max_q[c]) ? '0 : count_q[c] + W'(1);

            if (wrap)                              flag_d[c] = 1'b1;
            else if (wr_ctrl && bus.wr_data[2])    flag_d[c] = 1'b0;

            if (wr_ctrl) begin
                en_d[c]  = bus.wr_data[0];
                dir_d[c] = bus.wr_data[1];
                ie_d[c]  = bus.wr_data[3];
`ifdef TIMER_COUNTER_ONESHOT_EN
                os_d[c]  = bus.wr_data[4];
            end else if (wrap && os_q[c]) begin
                en_d[c]  = 1'b0;
`endif
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (chan_ok && (chan == 5'(c))) begin
                case (off)
                    2'd0: rd_mux = max_q[c];
`ifdef TIMER_COUNTER_ONESHOT_EN
                    2'd1: rd_mux = W'({os_q[c], ie_q[c], flag_q[c], dir_q[c], en_q[c]});
`else
                    2'd1: rd_mux = W'({ie_q[c], flag_q[c], dir_q[c], en_q[c]});
`endif
                    2'd2: rd_mux = period_q[c];
                    default: rd_mux = count_q[c];
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                max_q[c]    <= '0;
                period_q[c] <= '0;
                pre_q[c]    <= '0;
                count_q[c]  <= '0;
            end
            en_q      <= '0;
            dir_q     <= '0;
            flag_q    <= '0;
            ie_q      <= '0;
`ifdef TIMER_COUNTER_ONESHOT_EN
            os_q      <= '0;
`endif
            rd_data_q <= '0;
        end else begin
            max_q    <= max_d;
            period_q <= period_d;
            pre_q    <= pre_d;
            count_q  <= count_d;
            en_q     <= en_d;
            dir_q    <= dir_d;
            flag_q   <= flag_d;
            ie_q     <= ie_d;
`ifdef TIMER_COUNTER_ONESHOT_EN
            os_q     <= os_d;
`endif
            if (bus.rd_en) rd_data_q <= rd_mux;
        end
    end

    assign bus.rd_data = rd_data_q;
    assign bus.irq     = flag_q & ie_q;

endmodule

// File: doc/timer_counter_bank.md
# timer_counter_bank

Parametrised bank of NUM_CHANNELS independent memory-mapped timer/counters. Each channel has a clock-cycle prescaler, up/down counting, auto-reload at a programmable limit, and a sticky interrupt flag with enable. It sits on the I/O device bus next to the parallel ports. It adds write/read strobes, a registered read path and per-channel interrupt lines to the earlier single-reset timer block.

## Interface
- NUM_CHANNELS, 4, number of timer/counter channels (1..16)
- TIMER_COUNTER_WIDTH, 8, width of every register and counter (min 5)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- addr  in  $clog2(NUM_CHANNELS)+2  register address: {channel, offset[1:0]}
- wr_en  in  1  write strobe, one-cycle
- wr_data  in  TIMER_COUNTER_WIDTH  write data
- rd_en  in  1  read strobe, one-cycle
- rd_data  out  TIMER_COUNTER_WIDTH  registered read data
- irq  out  NUM_CHANNELS  per-channel interrupt, level: flag & ie

## Operation
- Per-channel registers, by offset:
  - 0 MAX: reload/limit value.
  - 1 CTRL: bit0 en, bit1 dir (0 up, 1 down), bit2 flag (read; write 1 clears), bit3 ie, others read 0.
  - 2 PERIOD: prescale; one tick every PERIOD+1 clocks.
  - 3 COUNT: current count; writable.
- Internal prescaler per channel, not addressable.
  - If en=1: prescaler == PERIOD -> tick, prescaler <= 0; otherwise prescaler+1.
  - If en=0: prescaler and COUNT hold.
- Tick, up mode: COUNT == MAX -> COUNT <= 0, flag <= 1; otherwise COUNT+1.
- Tick, down mode: COUNT == 0 -> COUNT <= MAX, flag <= 1; otherwise COUNT-1.
- Arithmetic is modulo 2^TIMER_COUNTER_WIDTH.
- Up mode with COUNT > MAX (after a write): counts up to all-ones, wraps to 0, continues to MAX. No flag is set on that wrap.
- MAX=0 gives a flag on every tick in either direction.
- Write to COUNT loads wr_data and clears that channel's prescaler to 0.
- Write to PERIOD also clears the prescaler.
- Channel index >= NUM_CHANNELS: writes ignored, reads return 0.
- Simultaneous events:
  - Bus write to COUNT and tick in the same cycle: write wins, tick lost.
  - Flag set and W1C in the same cycle: set wins, flag stays 1.
  - Write to CTRL takes effect on the next cycle. A tick in the write cycle uses the old dir/en.
- Reset (rst=0, any time, mid-count included): all registers, prescalers, flags and rd_data go to 0, irq=0 immediately (async). Counting resumes only after software sets en.

## Timing
- Writes: wr_en sampled on a rising clk edge; register updated at that edge.
- Reads: rd_en sampled at edge N; rd_data valid after edge N and held until the next rd_en. rd_data is 0 after reset.
- Read-after-write to the same register in consecutive cycles returns the new value.
- PERIOD=P, en set at edge E: first tick at edge E+P+1, then every P+1 clocks.
- flag rises at the wrap-tick edge. irq follows combinationally from flag & ie with no extra latency.
- No combinational path from addr/wr_data to rd_data or irq.

## Configuration
- TIMER_COUNTER_ONESHOT_EN defined:
  - CTRL bit4 = oneshot, read/write.
  - With oneshot=1, the wrap tick sets flag, performs the reload, and clears en in the same edge. The channel then stops.
- Undefined: bit4 is ignored on write and reads 0. Channels always free-run.

## Test plan
- Reset, then read all 4*NUM_CHANNELS addresses -> every value 0. irq=0.
- Ch0: MAX=3, PERIOD=0, CTRL=0x09 (en, up, ie) -> COUNT 1,2,3,0 on consecutive clocks. flag and irq[0] assert at the 0-wrap. Writing CTRL=0x0D clears the flag and keeps en/ie.
- Ch1: MAX=5, PERIOD=2, COUNT=2, CTRL=0x03 (en, down) -> decrement every 3 clocks: 1, 0, then reload 5 with flag set. irq[1] stays 0 (ie=0).
- Ch2 running: write COUNT=7 in the same cycle a tick is due -> COUNT reads 7. Next tick occurs PERIOD+1 clocks later.
- Assert rst low mid-count on ch0 and ch3 -> irq drops immediately. After release all registers read 0 and COUNT stays 0 for 20 clocks.
- With TIMER_COUNTER_ONESHOT_EN: ch0 MAX=2, CTRL=0x19 -> counts 1,2,0 then stops at 0. CTRL reads 0x1C (en cleared, flag set). Without the macro, the same write reads back 0x09 and the channel free-runs.
